// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Contains the arbiter state encoding and the "no store" memwrite code.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [1:0] MW_NONE = 2'b00;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch and a data requester.
// Reads take LAT cycles plus a registered valid pulse; stores complete in one cycle.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int N   = 64,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_req,
  input  logic [31:0]  if_adr,
  output logic [31:0]  if_rdata,
  output logic         if_valid,
  input  logic         d_req,
  input  logic [N-1:0] d_adr,
  input  logic [N-1:0] d_wdata,
  input  logic [1:0]   d_memwrite,
  input  logic         d_dword,
  output logic [N-1:0] d_rdata,
  output logic         d_valid,
  output logic [N-1:0] m_adr,
  output logic [N-1:0] m_wdata,
  output logic [1:0]   m_memwrite,
  output logic         m_dword,
  input  logic [N-1:0] m_rdata,
  output logic         stall
);

  localparam logic [2:0] LAST_CNT = 3'(LAT - 1);

  state_t       r_state;
  state_t       r_last_gnt;
  logic [2:0]   r_cnt;
  logic         r_if_valid;
  logic         r_d_valid;
  logic [31:0]  r_if_rdata;
  logic [N-1:0] r_d_rdata;

  state_t       w_next_state;
  logic         w_store;
  logic         w_read_done;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    m_adr        = '0;
    m_wdata      = '0;
    m_memwrite   = MW_NONE;
    m_dword      = 1'b0;
    w_store      = (r_state == ST_DATA) && (r_cnt == 3'd0) && (d_memwrite != MW_NONE);
    w_read_done  = (r_state != ST_IDLE) && !w_store && (r_cnt == LAST_CNT);

    case (r_state)
      ST_IDLE: begin
        // A cycle carrying a completion pulse never grants, so the finishing
        // requester's still-high request cannot be mistaken for a new one.
        if (!(r_if_valid || r_d_valid)) begin
          if (if_req && d_req) begin
            w_next_state = (r_last_gnt == ST_FETCH) ? ST_DATA : ST_FETCH;
          end else if (if_req) begin
            w_next_state = ST_FETCH;
          end else if (d_req) begin
            w_next_state = ST_DATA;
          end
        end
      end
      ST_FETCH: begin
        m_adr = N'(if_adr);
        if (w_read_done) w_next_state = ST_IDLE;
      end
      ST_DATA: begin
        m_adr   = d_adr;
        m_wdata = d_wdata;
        m_dword = d_dword;
        if (w_store) begin
          m_memwrite   = d_memwrite;
          w_next_state = ST_IDLE;
        end else if (w_read_done) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= ST_FETCH;
      r_cnt      <= '0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      if (r_state == ST_IDLE && w_next_state != ST_IDLE) r_last_gnt <= w_next_state;
      r_cnt <= (r_state != ST_IDLE && w_next_state != ST_IDLE) ? r_cnt + 3'd1 : '0;
      if (w_read_done) begin
        if (r_state == ST_FETCH) begin
          r_if_rdata <= m_rdata[31:0];
          r_if_valid <= 1'b1;
        end else begin
          r_d_rdata <= m_rdata;
          r_d_valid <= 1'b1;
        end
      end
    end
  end

  assign if_valid = r_if_valid;
  assign d_valid  = r_d_valid | w_store;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;
  assign stall    = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: LAT=1 and LAT=3 instances share stimulus; a transaction-level
// model is compared every cycle, plus literal expectations for the directed scenarios.
module tb_mem_arbiter;

  localparam int N = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         if_req;
  logic [31:0]  if_adr;
  logic         d_req;
  logic [N-1:0] d_adr;
  logic [N-1:0] d_wdata;
  logic [1:0]   d_memwrite;
  logic         d_dword;
  logic [N-1:0] m_rdata;

  logic [31:0]  if_rdata_o   [2];
  logic         if_valid_o   [2];
  logic [N-1:0] d_rdata_o    [2];
  logic         d_valid_o    [2];
  logic [N-1:0] m_adr_o      [2];
  logic [N-1:0] m_wdata_o    [2];
  logic [1:0]   m_memwrite_o [2];
  logic         m_dword_o    [2];
  logic         stall_o      [2];

  mem_arbiter #(.N(N), .LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata_o[0]), .if_valid(if_valid_o[0]),
    .d_req(d_req), .d_adr(d_adr), .d_wdata(d_wdata), .d_memwrite(d_memwrite),
    .d_dword(d_dword), .d_rdata(d_rdata_o[0]), .d_valid(d_valid_o[0]),
    .m_adr(m_adr_o[0]), .m_wdata(m_wdata_o[0]), .m_memwrite(m_memwrite_o[0]),
    .m_dword(m_dword_o[0]), .m_rdata(m_rdata), .stall(stall_o[0])
  );

  mem_arbiter #(.N(N), .LAT(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata_o[1]), .if_valid(if_valid_o[1]),
    .d_req(d_req), .d_adr(d_adr), .d_wdata(d_wdata), .d_memwrite(d_memwrite),
    .d_dword(d_dword), .d_rdata(d_rdata_o[1]), .d_valid(d_valid_o[1]),
    .m_adr(m_adr_o[1]), .m_wdata(m_wdata_o[1]), .m_memwrite(m_memwrite_o[1]),
    .m_dword(m_dword_o[1]), .m_rdata(m_rdata), .stall(stall_o[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction model: who = 0 none, 1 fetch, 2 data; age = cycles already spent serving.
  typedef struct packed {
    logic [1:0]   who;
    logic [2:0]   age;
    logic [1:0]   last;
    logic         vif;
    logic         vd;
    logic [31:0]  if_rd;
    logic [N-1:0] d_rd;
  } model_t;

  localparam model_t MODEL_RST = '{who: 2'd0, age: 3'd0, last: 2'd1, vif: 1'b0, vd: 1'b0,
                                   if_rd: 32'd0, d_rd: '0};

  model_t mdl [2] = '{MODEL_RST, MODEL_RST};

  function automatic model_t step(input model_t s, input int lat, input logic fr,
                                  input logic dr, input logic [1:0] mw, input logic [N-1:0] rd);
    model_t n = s;
    n.vif = 1'b0;
    n.vd  = 1'b0;
    if (s.who == 2'd0) begin
      if (!(s.vif || s.vd) && (fr || dr)) begin
        if (fr && dr) n.who = (s.last == 2'd1) ? 2'd2 : 2'd1;
        else          n.who = fr ? 2'd1 : 2'd2;
        n.last = n.who;
        n.age  = 3'd0;
      end
    end else if (s.who == 2'd2 && s.age == 3'd0 && mw != 2'b00) begin
      n.who = 2'd0;
    end else if (int'(s.age) + 1 == lat) begin
      if (s.who == 2'd1) begin n.if_rd = rd[31:0]; n.vif = 1'b1; end
      else               begin n.d_rd  = rd;       n.vd  = 1'b1; end
      n.who = 2'd0;
    end else begin
      n.age = s.age + 3'd1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) mdl[k] <= MODEL_RST;
      else       mdl[k] <= step(mdl[k], (k == 0) ? 1 : 3, if_req, d_req, d_memwrite, m_rdata);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      model_t       s;
      logic         e_dv;
      logic [N-1:0] e_adr;
      s     = mdl[k];
      e_dv  = s.vd | (s.who == 2'd2 && s.age == 3'd0 && d_memwrite != 2'b00);
      e_adr = (s.who == 2'd1) ? N'(if_adr) : (s.who == 2'd2) ? d_adr : '0;
      check($sformatf("u%0d_if_valid", k), 64'(if_valid_o[k]), 64'(s.vif));
      check($sformatf("u%0d_d_valid", k), 64'(d_valid_o[k]), 64'(e_dv));
      check($sformatf("u%0d_if_rdata", k), 64'(if_rdata_o[k]), 64'(s.if_rd));
      check($sformatf("u%0d_d_rdata", k), d_rdata_o[k], s.d_rd);
      check($sformatf("u%0d_m_adr", k), m_adr_o[k], e_adr);
      check($sformatf("u%0d_m_wdata", k), m_wdata_o[k], (s.who == 2'd2) ? d_wdata : '0);
      check($sformatf("u%0d_m_memwrite", k), 64'(m_memwrite_o[k]),
            64'((s.who == 2'd2 && s.age == 3'd0) ? d_memwrite : 2'b00));
      check($sformatf("u%0d_m_dword", k), 64'(m_dword_o[k]), 64'((s.who == 2'd2) ? d_dword : 1'b0));
      check($sformatf("u%0d_stall", k), 64'(stall_o[k]),
            64'((if_req & ~s.vif) | (d_req & ~e_dv)));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  int pulses;

  initial begin
    if_req = 1'b0; if_adr = '0; d_req = 1'b0; d_adr = '0; d_wdata = '0;
    d_memwrite = 2'b00; d_dword = 1'b0; m_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_if_valid", 64'(if_valid_o[0]), 64'd0);
    check("rst_d_valid", 64'(d_valid_o[0]), 64'd0);
    check("rst_if_rdata", 64'(if_rdata_o[0]), 64'd0);
    check("rst_d_rdata", d_rdata_o[0], 64'd0);
    check("rst_m_memwrite", 64'(m_memwrite_o[0]), 64'd0);
    check("rst_m_adr", m_adr_o[0], 64'd0);
    check("rst_stall", 64'(stall_o[0]), 64'd0);
    next_cycle();

    // Fetch, LAT=1: valid in cycle 3, stall falls with it
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) begin if_req = 1'b1; if_adr = 32'h10; m_rdata = 64'hFFFF_0000_2008_0005; end
      if (c == 4) if_req = 1'b0;
      @(negedge clk);
      check($sformatf("s1_if_valid_c%0d", c), 64'(if_valid_o[0]), 64'(c == 3));
      check($sformatf("s1_stall_c%0d", c), 64'(stall_o[0]), 64'(c < 3));
      if (c == 3) check("s1_if_rdata", 64'(if_rdata_o[0]), 64'h2008_0005);
      next_cycle();
    end
    idle(6);

    // Store: exactly one cycle of m_memwrite=01 with d_valid
    for (int c = 1; c <= 5; c++) begin
      if (c == 1) begin d_req = 1'b1; d_memwrite = 2'b01; d_adr = 64'h54; d_wdata = 64'd7; end
      if (c == 3) begin d_req = 1'b0; d_memwrite = 2'b00; end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("s2_u%0d_memwrite_c%0d", k, c), 64'(m_memwrite_o[k]), (c == 2) ? 64'd1 : 64'd0);
        check($sformatf("s2_u%0d_d_valid_c%0d", k, c), 64'(d_valid_o[k]), 64'(c == 2));
      end
      if (c == 2) begin
        check("s2_m_adr", m_adr_o[0], 64'h54);
        check("s2_m_wdata", m_wdata_o[0], 64'd7);
      end
      next_cycle();
    end
    idle(4);

    // Tie held from reset: DATA first, then FETCH
    reset = 1'b1;
    if_req = 1'b1; if_adr = 32'h100; d_req = 1'b1; d_adr = 64'h200; d_memwrite = 2'b00; d_dword = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      m_rdata = 64'hA000_0000_1234_0000 + 64'(c);
      if (c == 4) d_req = 1'b0;
      if (c == 7) if_req = 1'b0;
      @(negedge clk);
      check($sformatf("s3_d_valid_c%0d", c), 64'(d_valid_o[0]), 64'(c == 3));
      check($sformatf("s3_if_valid_c%0d", c), 64'(if_valid_o[0]), 64'(c == 6));
      if (c == 2) begin
        check("s3_grant1_adr", m_adr_o[0], 64'h200);
        check("s3_grant1_dword", 64'(m_dword_o[0]), 64'd1);
      end
      if (c == 3) check("s3_d_rdata", d_rdata_o[0], 64'hA000_0000_1234_0002);
      if (c == 5) check("s3_grant2_adr", m_adr_o[0], 64'h100);
      if (c == 6) check("s3_if_rdata", 64'(if_rdata_o[0]), 64'h1234_0005);
      if (c == 8) check("s3_idle_adr", m_adr_o[0], 64'd0);
      next_cycle();
    end
    d_dword = 1'b0;
    idle(4);

    // LAT=3 load: d_valid four cycles after grant, data from third cycle in state
    for (int c = 1; c <= 8; c++) begin
      m_rdata = 64'h5555_0000_0000_0000 + 64'(c);
      if (c == 1) begin d_req = 1'b1; d_memwrite = 2'b00; d_adr = 64'h88; end
      if (c == 6) d_req = 1'b0;
      @(negedge clk);
      check($sformatf("s4_d_valid_c%0d", c), 64'(d_valid_o[1]), 64'(c == 5));
      if (c == 2) check("s4_m_adr", m_adr_o[1], 64'h88);
      if (c == 5) check("s4_d_rdata", d_rdata_o[1], 64'h5555_0000_0000_0004);
      next_cycle();
    end
    idle(6);

    // Reset pulse during a LAT=3 fetch aborts it
    for (int c = 1; c <= 10; c++) begin
      m_rdata = 64'h0BAD_F00D_CAFE_0000 + 64'(c);
      if (c == 1) begin if_req = 1'b1; if_adr = 32'h40; end
      if (c == 3) begin reset = 1'b1; if_req = 1'b0; end
      if (c == 5) reset = 1'b0;
      @(negedge clk);
      check($sformatf("s5_no_if_valid_c%0d", c), 64'(if_valid_o[1]), 64'd0);
      if (c == 3) begin
        check("s5_rst_if_rdata", 64'(if_rdata_o[1]), 64'd0);
        check("s5_rst_d_rdata", d_rdata_o[1], 64'd0);
        check("s5_rst_m_adr", m_adr_o[1], 64'd0);
        check("s5_rst_m_memwrite", 64'(m_memwrite_o[1]), 64'd0);
        check("s5_rst_d_valid", 64'(d_valid_o[1]), 64'd0);
        check("s5_rst_stall", 64'(stall_o[1]), 64'd0);
      end
      next_cycle();
    end
    for (int c = 1; c <= 7; c++) begin
      m_rdata = 64'h0BAD_F00D_CAFE_0000 + 64'(c);
      if (c == 1) begin if_req = 1'b1; if_adr = 32'h44; end
      if (c == 6) if_req = 1'b0;
      @(negedge clk);
      check($sformatf("s5b_if_valid_c%0d", c), 64'(if_valid_o[1]), 64'(c == 5));
      if (c == 5) check("s5b_if_rdata", 64'(if_rdata_o[1]), 64'hCAFE_0004);
      next_cycle();
    end
    idle(6);

    // Fetch request dropped one cycle after grant still completes once
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) begin if_req = 1'b1; if_adr = 32'h80; m_rdata = 64'h1111_2222_3333_4444; end
      if (c == 2) if_req = 1'b0;
      @(negedge clk);
      if (if_valid_o[0]) pulses++;
      check($sformatf("s6_u0_if_valid_c%0d", c), 64'(if_valid_o[0]), 64'(c == 3));
      check($sformatf("s6_u1_if_valid_c%0d", c), 64'(if_valid_o[1]), 64'(c == 5));
      if (c == 3) check("s6_if_rdata", 64'(if_rdata_o[0]), 64'h3333_4444);
      if (c == 4) check("s6_idle_adr", m_adr_o[0], 64'd0);
      next_cycle();
    end
    check("s6_pulse_count", 64'(pulses), 64'd1);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 64, data/address width of the data port and memory port.
REQ-002 Parameter LAT, default 1, memory read latency in cycles (range 1..7).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 if_req  input  1  instruction fetch request, held until if_valid.
REQ-006 if_adr  input  32  fetch address, stable while if_req is high.
REQ-007 if_rdata  output  32  fetched instruction, meaningful while if_valid is high.
REQ-008 if_valid  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data access request, held until d_valid.
REQ-010 d_adr  input  N  data address.
REQ-011 d_wdata  input  N  store data.
REQ-012 d_memwrite  input  2  store enable code; 2'b00 = load, nonzero = store (code is passed through).
REQ-013 d_dword  input  1  64-bit access select, passed through.
REQ-014 d_rdata  output  N  load data, meaningful while d_valid is high.
REQ-015 d_valid  output  1  one-cycle data completion pulse.
REQ-016 m_adr  output  N  shared memory address; fetch addresses are zero-extended.
REQ-017 m_wdata, m_memwrite, m_dword  output  N/2/1  shared memory store controls.
REQ-018 m_rdata  input  N  shared memory read data; fetch uses m_rdata[31:0].
REQ-019 stall  output  1  high whenever any request is pending and has not yet completed.

Function
REQ-020 The FSM SHALL have the states IDLE, FETCH, DATA.
REQ-021 In IDLE with exactly one request high, the FSM SHALL grant that requester on the next edge.
REQ-022 In IDLE with both requests high, the FSM SHALL grant the requester not granted last time (last_gnt register; reset value = fetch, so data wins the first tie).
REQ-023 In FETCH/DATA, m_adr and the other m_* outputs SHALL drive the granted requester's inputs; m_memwrite SHALL be 2'b00 except as in REQ-024.
REQ-024 Data store: m_memwrite SHALL equal d_memwrite for exactly the first cycle in DATA; d_valid SHALL pulse that cycle; the FSM SHALL return to IDLE.
REQ-025 Reads (fetch or load): a latency counter SHALL count LAT cycles in state; on the LAT-th cycle m_rdata SHALL be registered into if_rdata/d_rdata, the valid SHALL pulse on the following cycle, and the FSM SHALL return to IDLE.
REQ-026 Read data outputs SHALL hold their last captured value until the next capture.
REQ-027 A valid pulse and a new grant SHALL NOT both occur in the same cycle; IDLE is always visited for one cycle between grants.
REQ-028 The FSM SHALL ignore a request drop mid-transaction; the transaction completes and the valid is still issued.
REQ-029 In IDLE with no requests, m_memwrite SHALL be 2'b00 and m_adr SHALL be 0.
REQ-030 stall SHALL be combinational: (if_req & ~if_valid) | (d_req & ~d_valid).

Reset
REQ-031 Reset SHALL force: state IDLE, counter 0, last_gnt = fetch, if_valid = d_valid = 0, if_rdata = d_rdata = 0, m_memwrite = 2'b00.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction with no valid pulse and no further store cycle.

Structure
REQ-033 The state enum (IDLE/FETCH/DATA) and the memwrite "no store" constant 2'b00 SHALL be placed in shared package mem_pkg.
REQ-034 The implementation SHALL be a single module; no sub-modules.

Verification
REQ-035 Fetch only, LAT=1: if_req with if_adr=0x10 and m_rdata=0x20080005 -> if_valid pulses at cycle 3, if_rdata=0x20080005, stall falls with the pulse.
REQ-036 Store: d_req, d_memwrite=2'b01, d_adr=0x54, d_wdata=7 -> exactly one cycle of m_memwrite=01 with m_adr=0x54, d_valid pulses in the same cycle.
REQ-037 Tie: if_req and d_req held from reset -> grant order DATA, FETCH, then IDLE; each valid pulses once.
REQ-038 LAT=3 load -> d_valid pulses 4 cycles after the grant, d_rdata equals m_rdata sampled on the 3rd cycle.
REQ-039 Reset pulse during a LAT=3 fetch -> no if_valid, all outputs reach their reset values, and a new fetch afterwards completes normally.
REQ-040 if_req dropped one cycle after the grant -> if_valid still pulses once and the FSM returns to IDLE.
